// File: rtl/conv1_ctrl.sv
// conv1_ctrl: sequences one conv1 frame from pixel memory into the
// line/window buffer and counts the windows it produces.
module conv1_ctrl #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int DATA_BITS   = 8,
    parameter int FILTER_SIZE = 7,
    parameter int ADDR_BITS   = 10,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] base_addr,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 calc_ready,
    input  logic                 buf_ready,
    output logic                 valid_in,
    output logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_out_buf,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [15:0]          win_count,
    output logic [15:0]          frame_count
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int NWIN = (HEIGHT - FILTER_SIZE + 1) * (WIDTH - FILTER_SIZE + 1);
    localparam int CW   = $clog2(NPIX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_WAIT_WIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] base_q;
    logic [CW-1:0]        issued;
    logic [TW-1:0]        timer;
    logic                 all_issued;
    logic                 issue;
    logic                 tmo;

    // Outputs decoded purely from registered state and counters.
    assign all_issued = (issued == CW'(NPIX));
    assign mem_req    = (state == S_LOAD) && !all_issued;
    assign issue      = mem_req && mem_gnt;
    assign mem_addr   = base_q + ADDR_BITS'(issued);
    assign data_in    = mem_rd_data;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign calc_ready = (state == S_ARM) || (state == S_LOAD) ||
                        (state == S_WAIT_WIN);
    assign tmo        = (timer == TW'(TIMEOUT - 1));

    // Frame sequencer: state, counters, stall timer and pixel strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            issued      <= '0;
            timer       <= '0;
            valid_in    <= 1'b0;
            win_count   <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            // An in-flight read still delivers its pixel, even after abort.
            valid_in <= issue;
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if ((state != S_IDLE) && abort) begin
                state <= S_IDLE;
                timer <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            base_q      <= base_addr;
                            issued      <= '0;
                            win_count   <= '0;
                            timeout_err <= 1'b0;
                            timer       <= '0;
                            state       <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (buf_ready) begin
                            timer <= '0;
                            state <= S_LOAD;
                        end else if (tmo) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        // The last strobe is visible once every read is issued.
                        if (valid_in && all_issued) begin
                            timer <= '0;
                            state <= S_WAIT_WIN;
                        end else if (issue) begin
                            timer <= '0;
                        end else if (tmo) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_WAIT_WIN: begin
                        if (valid_out_buf) begin
                            timer <= '0;
                            if (win_count != 16'hFFFF) begin
                                win_count <= win_count + 1'b1;
                            end
                            if (win_count == 16'(NWIN - 1)) begin
                                frame_count <= frame_count + 1'b1;
                                state       <= S_DONE;
                            end
                        end else if (tmo) begin
                            timeout_err <= 1'b1;
                            state       <= S_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    S_ERR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv1_ctrl.sv
// tb_conv1_ctrl: directed scenarios for the conv1 frame sequencer
// with a pixel-memory model and a simple window-emitting buffer model.
module tb_conv1_ctrl;

    localparam int AB   = 10;
    localparam int DB   = 8;
    localparam int NPIX = 784;
    localparam int NWIN = 484;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic          mem_req;
    logic          mem_gnt = 1'b0;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_rd_data = '0;
    logic          calc_ready;
    logic          buf_ready = 1'b0;
    logic          valid_in;
    logic [DB-1:0] data_in;
    logic          valid_out_buf = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [15:0]   win_count;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv1_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .calc_ready(calc_ready), .buf_ready(buf_ready),
        .valid_in(valid_in), .data_in(data_in),
        .valid_out_buf(valid_out_buf), .busy(busy), .done(done),
        .timeout_err(timeout_err), .win_count(win_count),
        .frame_count(frame_count)
    );

    function automatic logic [7:0] pix(input logic [AB-1:0] a);
        return {a[1:0], a[7:2]} ^ {6'b0, a[9:8]};
    endfunction

    // Pixel memory: data valid one cycle after each issued read.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) mem_rd_data <= pix(mem_addr);
    end

    int iss_total = 0, vin_total = 0, done_total = 0, req_total = 0;
    int clow_total = 0, stray_total = 0, addr_err = 0, data_err = 0;
    int idx = 0;
    logic [AB-1:0] base_m = '0, addr24 = '0, exp_a, pop_a;
    logic [AB-1:0] aq[$];

    // Bus monitor: event counters plus address/data order scoreboard.
    always @(posedge clk) begin
        if (!rst) begin
            if (start && !busy) begin
                idx = 0;
                base_m = base_addr;
                aq.delete();
            end
            if (mem_req) req_total++;
            if (busy && !calc_ready) clow_total++;
            if (done) done_total++;
            if (valid_in) begin
                vin_total++;
                if (!calc_ready) stray_total++;
                if (aq.size() == 0) data_err++;
                else begin
                    pop_a = aq.pop_front();
                    if (data_in !== pix(pop_a)) data_err++;
                end
            end
            if (mem_req && mem_gnt) begin
                exp_a = base_m + AB'(idx);
                if (mem_addr !== exp_a) addr_err++;
                if (idx == 24) addr24 = mem_addr;
                aq.push_back(mem_addr);
                idx++;
                iss_total++;
            end
        end
    end

    int win_at_start, drv_timeout, rst_win_obs;

    task automatic drive_frame(input logic [AB-1:0] base, input int pct,
                               input int abort_at, input int rst_at_win,
                               input int restart_cyc);
        int cyc, sent, i0, v0;
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = ~base;
        win_at_start = win_count;
        i0 = iss_total;
        v0 = vin_total;
        sent = 0;
        cyc = 0;
        drv_timeout = 0;
        while (busy) begin
            if (cyc >= 20000) begin
                drv_timeout = 1;
                break;
            end
            if (rst_at_win >= 0 && sent == rst_at_win) begin
                rst_win_obs = win_count;
                valid_out_buf = 1'b0;
                rst = 1'b1;
                break;
            end
            buf_ready = (cyc >= 2);
            mem_gnt = (int'($urandom_range(0, 99)) < pct);
            valid_out_buf = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            if (vin_total - v0 == NPIX) begin
                if (sent < NWIN && cyc % 2 == 0) begin
                    valid_out_buf = 1'b1;
                    sent++;
                end
            end else if (cyc % 5 == 0) begin
                valid_out_buf = 1'b1;
            end
            if (abort_at >= 0 && iss_total - i0 == abort_at) abort = 1'b1;
            if (cyc == restart_cyc) start = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        valid_out_buf = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        buf_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, mem_req, calc_ready, valid_in, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, mem_req, calc_ready, valid_in, timeout_err});
        end
        n_checks++;
        if (win_count !== 16'd0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", win_count, frame_count);
        end
        n_checks++;
        if (mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d want 0", mem_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int i0, v0, a0, d0, n0, c0;
        i0 = iss_total; v0 = vin_total; a0 = addr_err;
        d0 = data_err; n0 = done_total; c0 = clow_total;
        drive_frame(10'd0, 100, -1, -1, -1);
        n_checks++;
        if (drv_timeout !== 0) begin
            n_fail++;
            $display("FAIL nom_bound: got %0d want 0", drv_timeout);
        end
        n_checks++;
        if (iss_total - i0 !== NPIX) begin
            n_fail++;
            $display("FAIL nom_issues: got %0d want %0d", iss_total - i0, NPIX);
        end
        n_checks++;
        if (addr_err - a0 !== 0) begin
            n_fail++;
            $display("FAIL nom_addr: got %0d errors want 0", addr_err - a0);
        end
        n_checks++;
        if (vin_total - v0 !== NPIX) begin
            n_fail++;
            $display("FAIL nom_valid_in: got %0d want %0d", vin_total - v0, NPIX);
        end
        n_checks++;
        if (data_err - d0 !== 0) begin
            n_fail++;
            $display("FAIL nom_data: got %0d errors want 0", data_err - d0);
        end
        n_checks++;
        if (win_count !== 16'd484) begin
            n_fail++;
            $display("FAIL nom_win: got %0d want 484", win_count);
        end
        n_checks++;
        if (done_total - n0 !== 1) begin
            n_fail++;
            $display("FAIL nom_done: got %0d want 1", done_total - n0);
        end
        n_checks++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL nom_frames: got %0d want 1", frame_count);
        end
        n_checks++;
        if (clow_total - c0 !== 1) begin
            n_fail++;
            $display("FAIL nom_calc_low: got %0d want 1", clow_total - c0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_contention();
        int i0, v0, a0, d0, n0;
        i0 = iss_total; v0 = vin_total; a0 = addr_err;
        d0 = data_err; n0 = done_total;
        drive_frame(10'd1000, 30, -1, -1, -1);
        n_checks++;
        if (iss_total - i0 !== NPIX || vin_total - v0 !== NPIX) begin
            n_fail++;
            $display("FAIL arb_counts: got %0d/%0d want %0d/%0d",
                     iss_total - i0, vin_total - v0, NPIX, NPIX);
        end
        n_checks++;
        if (addr_err - a0 !== 0 || data_err - d0 !== 0) begin
            n_fail++;
            $display("FAIL arb_order: got %0d/%0d errors want 0/0",
                     addr_err - a0, data_err - d0);
        end
        n_checks++;
        if (addr24 !== 10'd0) begin
            n_fail++;
            $display("FAIL arb_wrap: got %0d want 0", addr24);
        end
        n_checks++;
        if (win_count !== 16'd484 || frame_count !== 16'd2 || done_total - n0 !== 1) begin
            n_fail++;
            $display("FAIL arb_done: got %0d/%0d/%0d want 484/2/1",
                     win_count, frame_count, done_total - n0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, s0, n0;
        v0 = vin_total; s0 = stray_total; n0 = done_total;
        for (int k = 0; k < 3; k++) begin
            drive_frame(AB'(5 + 10 * k), 100, -1, -1, -1);
            n_checks++;
            if (win_at_start !== 16'd0) begin
                n_fail++;
                $display("FAIL b2b_win_clear: got %0d want 0", win_at_start);
            end
        end
        n_checks++;
        if (frame_count !== 16'd5 || done_total - n0 !== 3) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d/%0d want 5/3",
                     frame_count, done_total - n0);
        end
        n_checks++;
        if (vin_total - v0 !== 3 * NPIX || stray_total - s0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_valid_in: got %0d/%0d want %0d/0",
                     vin_total - v0, stray_total - s0, 3 * NPIX);
        end
    endtask

    task automatic test_timeout();
        int r0, n0, v0;
        r0 = req_total; n0 = done_total; v0 = vin_total;
        drive_frame(10'd0, 0, -1, -1, -1);
        n_checks++;
        if (req_total - r0 !== 1024) begin
            n_fail++;
            $display("FAIL tmo_cycles: got %0d want 1024", req_total - r0);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_flag: got %b/%b want 1/0", timeout_err, busy);
        end
        n_checks++;
        if (done_total - n0 !== 0 || frame_count !== 16'd5 || vin_total - v0 !== 0) begin
            n_fail++;
            $display("FAIL tmo_no_done: got %0d/%0d/%0d want 0/5/0",
                     done_total - n0, frame_count, vin_total - v0);
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_restart: got %b/%b want 1/0", busy, timeout_err);
        end
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || calc_ready !== 1'b0 || frame_count !== 16'd5) begin
            n_fail++;
            $display("FAIL tmo_abort_arm: got %b/%b/%0d want 0/0/5",
                     busy, calc_ready, frame_count);
        end
    endtask

    task automatic test_abort();
        int i0, v0, s0, n0, a0, d0;
        i0 = iss_total; v0 = vin_total; s0 = stray_total;
        n0 = done_total; a0 = addr_err; d0 = data_err;
        drive_frame(10'd100, 100, 400, -1, 10);
        n_checks++;
        if (busy !== 1'b0 || calc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b/%b want 0/0", busy, calc_ready);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (iss_total - i0 !== 401 || vin_total - v0 !== 401) begin
            n_fail++;
            $display("FAIL abort_counts: got %0d/%0d want 401/401",
                     iss_total - i0, vin_total - v0);
        end
        n_checks++;
        if (stray_total - s0 !== 1) begin
            n_fail++;
            $display("FAIL abort_tail: got %0d want 1", stray_total - s0);
        end
        n_checks++;
        if (addr_err - a0 !== 0 || data_err - d0 !== 0) begin
            n_fail++;
            $display("FAIL abort_restart_ignored: got %0d/%0d errors want 0/0",
                     addr_err - a0, data_err - d0);
        end
        n_checks++;
        if (done_total - n0 !== 0 || frame_count !== 16'd5) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d/%0d want 0/5",
                     done_total - n0, frame_count);
        end
    endtask

    task automatic test_reset_mid();
        int i0, v0, n0, a0, d0;
        drive_frame(10'd0, 100, -1, 200, -1);
        #1;
        n_checks++;
        if (rst_win_obs !== 200) begin
            n_fail++;
            $display("FAIL rmid_win_before: got %0d want 200", rst_win_obs);
        end
        n_checks++;
        if ({busy, done, mem_req, calc_ready, valid_in, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL rmid_flags: got %b want 000000",
                     {busy, done, mem_req, calc_ready, valid_in, timeout_err});
        end
        n_checks++;
        if (win_count !== 16'd0 || frame_count !== 16'd0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL rmid_counts: got %0d/%0d/%0d want 0/0/0",
                     win_count, frame_count, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        i0 = iss_total; v0 = vin_total; n0 = done_total;
        a0 = addr_err; d0 = data_err;
        drive_frame(10'd50, 100, -1, -1, -1);
        n_checks++;
        if (iss_total - i0 !== NPIX || vin_total - v0 !== NPIX) begin
            n_fail++;
            $display("FAIL rmid_frame_counts: got %0d/%0d want %0d/%0d",
                     iss_total - i0, vin_total - v0, NPIX, NPIX);
        end
        n_checks++;
        if (addr_err - a0 !== 0 || data_err - d0 !== 0) begin
            n_fail++;
            $display("FAIL rmid_frame_order: got %0d/%0d errors want 0/0",
                     addr_err - a0, data_err - d0);
        end
        n_checks++;
        if (win_count !== 16'd484 || frame_count !== 16'd1 || done_total - n0 !== 1) begin
            n_fail++;
            $display("FAIL rmid_frame_done: got %0d/%0d/%0d want 484/1/1",
                     win_count, frame_count, done_total - n0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv1_ctrl.md
Name: conv1_ctrl

Overview:
- Sequencer for the conv1 line/window buffer: arms it, streams one WIDTH×HEIGHT image from a shared pixel memory into it, and counts the FILTER_SIZE×FILTER_SIZE windows it emits.
- Sits between the layer-level scheduler (start/done), the pixel-memory arbiter (req/gnt) and the conv1 buffer (calc_ready, buf_ready, valid_in, data_in, valid_out_buf).
- Reports per-frame completion, window count, frame count and stall timeout.

Parameters:
- WIDTH, 28, image width in pixels
- HEIGHT, 28, image height in pixels
- DATA_BITS, 8, pixel width
- FILTER_SIZE, 7, square window size
- ADDR_BITS, 10, pixel memory address width (2^ADDR_BITS ≥ WIDTH*HEIGHT)
- TIMEOUT, 1024, max idle cycles tolerated while waiting on the buffer

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- abort  in  1  synchronous abort of the current frame
- base_addr  in  ADDR_BITS  frame start address, latched on accepted start
- mem_req  out  1  pixel read request to arbiter
- mem_gnt  in  1  arbiter grant; a read issues in any cycle with mem_req&mem_gnt
- mem_addr  out  ADDR_BITS  read address, valid while mem_req
- mem_rd_data  in  DATA_BITS  read data, valid exactly 1 cycle after issue
- calc_ready  out  1  buffer enable; low clears buffer
- buf_ready  in  1  buffer accepting pixels
- valid_in  out  1  pixel strobe to buffer
- data_in  out  DATA_BITS  pixel to buffer (= mem_rd_data)
- valid_out_buf  in  1  buffer window-valid strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- timeout_err  out  1  sticky stall flag; cleared by next accepted start or reset
- win_count  out  16  windows counted in current/last frame
- frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async, any state): IDLE; all outputs 0; read/issue/window/timer counters 0. Reset mid-frame abandons the frame with no done.
- Constants: NPIX = WIDTH*HEIGHT (784); NWIN = (HEIGHT-FILTER_SIZE+1)*(WIDTH-FILTER_SIZE+1) (484).
- IDLE: calc_ready=0, mem_req=0. On start: latch base_addr; clear win_count, issue count and timeout_err; go to ARM next cycle.
- ARM: calc_ready=1. Wait for buf_ready=1, then go to LOAD. Timer counts cycles; TIMEOUT reached → ERR.
- LOAD:
  - mem_req=1 while issued < NPIX; mem_addr = base_addr + issued, modulo 2^ADDR_BITS.
  - Each issue (mem_req&mem_gnt) increments issued.
  - valid_in is a register set the cycle after each issue; data_in passes mem_rd_data combinationally.
  - No read issues while mem_gnt=0; gaps in valid_in are legal.
  - After the final valid_in (NPIX-th), go to WAIT_WIN. Exactly NPIX valid_in pulses per frame.
  - The timer resets on each issue. TIMEOUT consecutive cycles with no grant → ERR.
- WAIT_WIN:
  - Each cycle with valid_out_buf=1 increments win_count (saturates at 0xFFFF) and resets the timer.
  - When win_count reaches NWIN, go to DONE.
  - TIMEOUT cycles with no window → ERR.
  - A valid_out_buf seen outside WAIT_WIN is ignored.
- DONE (1 cycle): done=1, frame_count+1, calc_ready=0 (one-cycle buffer clear); go to IDLE. win_count holds until next start.
- ERR (1 cycle): timeout_err=1 (sticky), calc_ready=0, mem_req=0; go to IDLE with no done pulse.
- abort: in any non-IDLE state, next state is IDLE and calc_ready drops the next cycle. Any in-flight read's valid_in still asserts one cycle later. No done pulse, frame_count unchanged. abort in IDLE has no effect.
- Priority: rst > abort > state logic. start while busy is ignored. start and abort together in IDLE: start wins (abort has no effect in IDLE).
- busy=1 from the cycle after an accepted start through the DONE/ERR cycle inclusive.

Test Plan:
- Nominal frame: base_addr=0, mem_gnt tied 1, buffer model per conv1 protocol → addresses 0..783 each issued once; 784 valid_in; win_count=484; done pulses once; frame_count=1; calc_ready low for exactly 1 cycle in DONE.
- Arbiter contention: mem_gnt random 30% duty, base_addr=1000 → addresses wrap 1000..1023 then 0..759; data_in order matches memory; still 784 valid_in and 484 windows.
- Back-to-back frames: start asserted in the cycle following done, 3 times → frame_count=3; win_count reset to 0 at each start; no valid_in outside LOAD (plus in-flight tail).
- Timeout: mem_gnt held 0 in LOAD → after 1024 idle cycles timeout_err=1, busy=0, no done. Next start clears timeout_err.
- Abort mid-LOAD at issue 400 → IDLE next cycle; calc_ready=0; ≤1 trailing valid_in; frame_count unchanged. start while busy is ignored.
- Async reset asserted mid-WAIT_WIN (win_count=200) → all outputs 0 immediately; a subsequent start runs a full clean frame.
